// File: rtl/scariv_lsu_issue_sched_if.sv
// Dispatch/pick/clear signal bundle between the LSU issue entries and their scheduler.
// master = entry array and dispatch side, slave = scheduler.
interface scariv_lsu_issue_sched_if #(
    parameter int ENTRY_SIZE = 8,
    parameter int IN_PORT    = 2
);
    localparam int LANE_W = (IN_PORT > 1) ? $clog2(IN_PORT) : 1;
    localparam int IDX_W  = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;
    localparam int CNT_W  = $clog2(ENTRY_SIZE + 1);

    logic [IN_PORT-1:0]           i_disp_valid;
    logic                         o_disp_ready;
    logic [ENTRY_SIZE-1:0]        o_entry_put;
    logic [ENTRY_SIZE*LANE_W-1:0] o_put_lane;
    logic [ENTRY_SIZE-1:0]        i_entry_ready;
    logic                         i_issue_stall;
    logic [ENTRY_SIZE-1:0]        o_entry_picked;
    logic                         o_pick_valid;
    logic [IDX_W-1:0]             o_pick_idx;
    logic [ENTRY_SIZE-1:0]        i_issue_succeeded;
    logic [ENTRY_SIZE-1:0]        o_clear_entry;
    logic [CNT_W-1:0]             o_free_cnt;
    logic                         o_empty;

    modport master (
        output i_disp_valid, i_entry_ready, i_issue_stall, i_issue_succeeded,
        input  o_disp_ready, o_entry_put, o_put_lane, o_entry_picked, o_pick_valid,
        input  o_pick_idx, o_clear_entry, o_free_cnt, o_empty
    );

    modport slave (
        input  i_disp_valid, i_entry_ready, i_issue_stall, i_issue_succeeded,
        output o_disp_ready, o_entry_put, o_put_lane, o_entry_picked, o_pick_valid,
        output o_pick_idx, o_clear_entry, o_free_cnt, o_empty
    );
endinterface

// File: rtl/scariv_lsu_issue_sched.sv
// LSU issue queue allocator plus oldest-first picker driven by an age matrix.
// Latency: put/pick/clear strobes are combinational; busy and age update on the next edge.
// Backpressure: o_disp_ready drops when fewer than IN_PORT entries are free; i_issue_stall masks the pick.
module scariv_lsu_issue_sched #(
    parameter int ENTRY_SIZE = 8,
    parameter int IN_PORT    = 2
) (
    input logic i_clk,
    input logic i_reset_n,
    scariv_lsu_issue_sched_if.slave bus
);
    localparam int LANE_W = (IN_PORT > 1) ? $clog2(IN_PORT) : 1;
    localparam int IDX_W  = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;
    localparam int CNT_W  = $clog2(ENTRY_SIZE + 1);

    logic [ENTRY_SIZE-1:0]                 r_busy;
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0] r_age;   // r_age[i][j]: entry i older than entry j

    logic [CNT_W-1:0]                  free_cnt;
    logic                              disp_ready;
    logic [ENTRY_SIZE-1:0]             put;
    logic [ENTRY_SIZE-1:0]             clr;
    logic [ENTRY_SIZE-1:0]             cand;
    logic [ENTRY_SIZE-1:0]             picked;
    logic [ENTRY_SIZE-1:0][LANE_W-1:0] lane;
    logic [IDX_W-1:0]                  pick_idx;

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (!r_busy[i]) free_cnt = free_cnt + CNT_W'(1);
        end
    end

    assign disp_ready = (free_cnt >= CNT_W'(IN_PORT));

    // The n-th free entry (lowest index first) belongs to lane n.
    always_comb begin
        int n;
        n    = 0;
        put  = '0;
        lane = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (!r_busy[i] && disp_ready) begin
                for (int k = 0; k < IN_PORT; k++) begin
                    if (k == n && bus.i_disp_valid[k]) begin
                        put[i]  = 1'b1;
                        lane[i] = LANE_W'(k);
                    end
                end
                n = n + 1;
            end
        end
    end

    assign clr  = bus.i_issue_succeeded & r_busy;
    assign cand = bus.i_entry_ready & r_busy;

    always_comb begin
        picked = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            picked[i] = cand[i] & ~bus.i_issue_stall;
            for (int j = 0; j < ENTRY_SIZE; j++) begin
                if (cand[j] && r_age[j][i]) picked[i] = 1'b0;
            end
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (picked[i]) pick_idx = pick_idx | IDX_W'(i);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy <= '0;
            r_age  <= '0;
        end else begin
            r_busy <= (r_busy | put) & ~clr;
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                for (int j = 0; j < ENTRY_SIZE; j++) begin
                    if (clr[i] || clr[j]) begin
                        r_age[i][j] <= 1'b0;
                    end else if (put[i]) begin
                        // Same-cycle puts: the lower lane is older in program order.
                        r_age[i][j] <= put[j] && (lane[i] < lane[j]);
                    end else if (put[j]) begin
                        r_age[i][j] <= r_busy[i];
                    end
                end
            end
        end
    end

    assign bus.o_disp_ready   = disp_ready;
    assign bus.o_entry_put    = put;
    assign bus.o_put_lane     = lane;
    assign bus.o_entry_picked = picked;
    assign bus.o_pick_valid   = |picked;
    assign bus.o_pick_idx     = pick_idx;
    assign bus.o_clear_entry  = clr;
    assign bus.o_free_cnt     = free_cnt;
    assign bus.o_empty        = ~|r_busy;

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (i_reset_n) begin
            assert ($onehot0(picked));
            assert (((bus.i_disp_valid + IN_PORT'(1)) & bus.i_disp_valid) == '0);
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                for (int j = 0; j < ENTRY_SIZE; j++) begin
                    if (i != j && r_busy[i] && r_busy[j]) assert (r_age[i][j] != r_age[j][i]);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_scariv_lsu_issue_sched.sv
// Directed scoreboard bench for scariv_lsu_issue_sched with 4 entries and 2 dispatch lanes.
module tb_scariv_lsu_issue_sched;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    scariv_lsu_issue_sched_if #(.ENTRY_SIZE(4), .IN_PORT(2)) bus ();

    scariv_lsu_issue_sched #(.ENTRY_SIZE(4), .IN_PORT(2)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    typedef struct {
        int       cyc;
        bit [3:0] put;
        bit [3:0] lane;
        bit [3:0] pick;
        bit [1:0] idx;
        bit [3:0] clr;
        int       free;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    task automatic chk(input string what, input int c, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL c%0d %s: got %0h expected %0h", c, what, act, want);
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare the presented outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("put",        e.cyc, 32'(bus.o_entry_put),    32'(e.put));
                chk("put_lane",   e.cyc, 32'(bus.o_put_lane),     32'(e.lane));
                chk("picked",     e.cyc, 32'(bus.o_entry_picked), 32'(e.pick));
                chk("pick_valid", e.cyc, 32'(bus.o_pick_valid),   32'(e.pick != 4'b0000));
                chk("pick_idx",   e.cyc, 32'(bus.o_pick_idx),     32'(e.idx));
                chk("clear",      e.cyc, 32'(bus.o_clear_entry),  32'(e.clr));
                chk("free_cnt",   e.cyc, 32'(bus.o_free_cnt),     32'(e.free));
                chk("disp_ready", e.cyc, 32'(bus.o_disp_ready),   32'(e.free >= 2));
                chk("empty",      e.cyc, 32'(bus.o_empty),        32'(e.free == 4));
            end
        end
    end

    task automatic cyc(input bit rst, input logic [1:0] dv, input logic [3:0] rdy, input bit stall,
                       input logic [3:0] succ, input bit [3:0] e_put, input bit [3:0] e_lane,
                       input bit [3:0] e_pick, input bit [1:0] e_idx, input bit [3:0] e_clr,
                       input int e_free);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n               = rst;
        bus.i_disp_valid      = dv;
        bus.i_entry_ready     = rdy;
        bus.i_issue_stall     = stall;
        bus.i_issue_succeeded = succ;
        e.cyc  = cyc_no;
        e.put  = e_put;
        e.lane = e_lane;
        e.pick = e_pick;
        e.idx  = e_idx;
        e.clr  = e_clr;
        e.free = e_free;
        exp_q.push_back(e);
        cyc_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_disp_valid      = '0;
        bus.i_entry_ready     = '0;
        bus.i_issue_stall     = 1'b0;
        bus.i_issue_succeeded = '0;
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        //   rst dv     rdy      st  succ     put      lane     pick     idx    clr      free
        cyc(1, 2'b00, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 4); // c0 reset state
        cyc(1, 2'b11, 4'b0000, 0, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 2'd0, 4'b0000, 4); // c1 lane0->e0 lane1->e1
        cyc(1, 2'b00, 4'b0011, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2); // c2 e0 older than e1
        cyc(1, 2'b11, 4'b0000, 0, 4'b0000, 4'b1100, 4'b1000, 4'b0000, 2'd0, 4'b0000, 2); // c3 fill at 2 free
        cyc(1, 2'b11, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0); // c4 full: no put
        cyc(1, 2'b11, 4'b1100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b0000, 0); // c5 e2 older than e3
        cyc(1, 2'b00, 4'b0000, 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b1011, 0); // c6 clear e0,e1,e3
        cyc(1, 2'b01, 4'b0000, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 4'b0000, 3); // c7 put e0 after e2
        cyc(1, 2'b11, 4'b0000, 0, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 2'd0, 4'b0000, 2); // c8 put e1, e3
        cyc(1, 2'b00, 4'b1101, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b0000, 0); // c9 oldest e2
        cyc(1, 2'b00, 4'b1001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 0); // c10 then e0
        cyc(1, 2'b00, 4'b1101, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 0); // c11 stall
        cyc(1, 2'b00, 4'b1000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 4'b0000, 0); // c12 youngest alone
        cyc(1, 2'b11, 4'b0000, 0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b1010, 0); // c13 clear e1,e3 + disp
        cyc(1, 2'b01, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0, 4'b0000, 2); // c14 next put takes e1
        cyc(1, 2'b00, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0100, 1); // c15 clear oldest e2
        cyc(1, 2'b01, 4'b0111, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2); // c16 put e2, pick e0
        cyc(1, 2'b00, 4'b0110, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b0000, 1); // c17 new e2 youngest
        cyc(1, 2'b00, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'b0000, 1); // c18 e2 pickable
        cyc(0, 2'b00, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 4); // c19 async reset
        cyc(1, 2'b11, 4'b0000, 0, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 2'd0, 4'b0000, 4); // c20 post-reset e0/e1
        @(posedge clk);
        #1;
        bus.i_disp_valid  = '0;
        bus.i_entry_ready = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
